// File: rtl/rtype_pkg.sv
// Shared definitions for the R-type sequencer: instruction fields, funct codes,
// ALU select codes and the sequencer state encoding.
package rtype_pkg;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int SHAMT_W   = SHAMT_MSB - SHAMT_LSB + 1;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_XOR = 6'h26;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;
  localparam logic [5:0] FUNCT_SRL = 6'h02;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [2:0] ALU_NOR = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    EXEC,
    SLT,
    WB,
    ERR
  } state_t;

endpackage

// File: rtl/rtype_funct_decode.sv
// Combinational decode of op/funct into the ALU select code and the
// classification flags the sequencer needs.
module rtype_funct_decode
  import rtype_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [2:0] alu_sel,
  output logic       legal,
  output logic       is_slt,
  output logic       is_shift
);

  always_comb begin
    alu_sel  = ALU_AND;
    legal    = 1'b0;
    is_slt   = 1'b0;
    is_shift = 1'b0;
    if (op == OP_RTYPE) begin
      legal = 1'b1;
      case (funct)
        FUNCT_ADD: alu_sel = ALU_ADD;
        FUNCT_SUB: alu_sel = ALU_SUB;
        FUNCT_AND: alu_sel = ALU_AND;
        FUNCT_OR:  alu_sel = ALU_OR;
        FUNCT_XOR: alu_sel = ALU_XOR;
        FUNCT_NOR: alu_sel = ALU_NOR;
        FUNCT_SRL: begin
          alu_sel  = ALU_SRL;
          is_shift = 1'b1;
        end
        // slt subtracts, then the sign is corrected for overflow in its own step
        FUNCT_SLT: begin
          alu_sel = ALU_SUB;
          is_slt  = 1'b1;
        end
        default:   legal = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/rtype_sequencer.sv
// Multi-cycle R-type sequencer: read operands, drive the shared ALU, write back rd.
// Optional build macro RTYPE_OVF_TRAP_EN turns add/sub signed overflow into an illegal trap.
module rtype_sequencer
  import rtype_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [REG_AW-1:0] rf_raddr1,
  output logic [REG_AW-1:0] rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_overflow,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              done,
  output logic              illegal,
  output logic              busy
);

  state_t state, state_nxt;

  logic [REG_AW-1:0]  rs_q, rt_q, rd_q;
  logic [SHAMT_W-1:0] shamt_q;
  logic [2:0]         sel_q;
  logic               slt_q, shift_q, ovf_q;
  logic [DATA_W-1:0]  opa_q, opb_q, result_q;

  logic [2:0] dec_sel;
  logic       dec_legal, dec_slt, dec_shift;
  logic       transfer, trap;

  rtype_funct_decode u_decode (
    .op       (instr[OP_MSB:OP_LSB]),
    .funct    (instr[FUNCT_MSB:FUNCT_LSB]),
    .alu_sel  (dec_sel),
    .legal    (dec_legal),
    .is_slt   (dec_slt),
    .is_shift (dec_shift)
  );

  assign instr_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign transfer    = instr_valid & instr_ready;

`ifdef RTYPE_OVF_TRAP_EN
  assign trap = alu_overflow & ~slt_q & ((sel_q == ALU_ADD) | (sel_q == ALU_SUB));
`else
  assign trap = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      shamt_q  <= '0;
      sel_q    <= '0;
      slt_q    <= 1'b0;
      shift_q  <= 1'b0;
      ovf_q    <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: if (transfer) begin
          rs_q    <= instr[RS_MSB:RS_LSB];
          rt_q    <= instr[RT_MSB:RT_LSB];
          rd_q    <= instr[RD_MSB:RD_LSB];
          shamt_q <= instr[SHAMT_MSB:SHAMT_LSB];
          sel_q   <= dec_sel;
          slt_q   <= dec_slt;
          shift_q <= dec_shift;
        end
        READ: begin
          opa_q <= rf_rdata1;
          opb_q <= rf_rdata2;
        end
        EXEC: begin
          result_q <= alu_result;
          ovf_q    <= alu_overflow;
        end
        // true signed less-than is the difference sign corrected by overflow
        SLT: result_q <= {{(DATA_W-1){1'b0}}, result_q[DATA_W-1] ^ ovf_q};
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (transfer) state_nxt = dec_legal ? READ : ERR;
      READ: state_nxt = EXEC;
      EXEC: begin
        if (trap)       state_nxt = ERR;
        else if (slt_q) state_nxt = SLT;
        else            state_nxt = WB;
      end
      SLT:  state_nxt = WB;
      WB:   state_nxt = IDLE;
      ERR:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read addresses come straight from the offered word in IDLE so the
  // register file sees them on the transfer edge.
  always_comb begin
    rf_raddr1 = rs_q;
    rf_raddr2 = rt_q;
    alu_sel   = '0;
    alu_a     = '0;
    alu_b     = '0;
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    done      = 1'b0;
    illegal   = 1'b0;
    if (state == IDLE) begin
      rf_raddr1 = instr[RS_MSB:RS_LSB];
      rf_raddr2 = instr[RT_MSB:RT_LSB];
    end
    if ((state == EXEC) || (state == SLT)) begin
      alu_sel = sel_q;
      alu_a   = shift_q ? opb_q : opa_q;
      alu_b   = shift_q ? {{(DATA_W-SHAMT_W){1'b0}}, shamt_q} : opb_q;
    end
    if (state == WB) begin
      rf_we    = (rd_q != '0);
      rf_waddr = rd_q;
      rf_wdata = result_q;
      done     = 1'b1;
    end
    if (state == ERR) illegal = 1'b1;
  end

endmodule
